// File: rtl/unit_scheduler.sv
// Batch command sequencer for NUM_UNITS processing units: dispatches one command per enabled unit,
// tracks completions, and reports batch latency and count. Optional watchdog: UNIT_SCHEDULER_WATCHDOG_EN.
module unit_scheduler #(
    parameter int NUM_UNITS = 4,
    parameter int ADDR_W    = 4,
    parameter int FUNC_W    = 2,
    parameter int PERF_W    = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start_i,
    input  logic                                    abort_i,
    input  logic                                    continue_en_i,
    input  logic [1:0]                              mode_i,
    input  logic [FUNC_W-1:0]                       func_i,
    input  logic [ADDR_W-1:0]                       base_addr_i,
    input  logic [NUM_UNITS-1:0]                    unit_enable_i,
    output logic [NUM_UNITS-1:0]                    cmd_valid_o,
    input  logic [NUM_UNITS-1:0]                    cmd_ready_i,
    output logic [NUM_UNITS*(2+FUNC_W+ADDR_W)-1:0]  cmd_data_o,
    input  logic [NUM_UNITS-1:0]                    unit_done_i,
    output logic                                    busy_o,
    output logic                                    sync_o,
    output logic                                    error_o,
    output logic [NUM_UNITS-1:0]                    active_mask_o,
    output logic [NUM_UNITS-1:0]                    timeout_mask_o,
    output logic [PERF_W-1:0]                       perf_cycles_o,
    output logic [15:0]                             batch_count_o
);

    localparam int CW = 2 + FUNC_W + ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_DISPATCH,
        S_EXECUTE,
        S_SYNC
    } state_t;

    state_t                     state_q, state_d;
    logic [NUM_UNITS-1:0]       pending_q, pending_d;
    logic [NUM_UNITS-1:0]       active_q, active_d;
    logic [NUM_UNITS*CW-1:0]    data_q, data_d;
    logic                       error_q, error_d;
    logic [NUM_UNITS-1:0]       tmask_q, tmask_d;
    logic [PERF_W-1:0]          cnt_q, cnt_d;
    logic [PERF_W-1:0]          perf_q, perf_d;
    logic [15:0]                batch_q, batch_d;

    logic [NUM_UNITS-1:0]       hs;
    logic [NUM_UNITS*CW-1:0]    slice_w;
    logic [1:0]                 opcode_w;
    logic [FUNC_W-1:0]          func_w;

    // Mode 00/01/10 maps to opcode 01/10/11; func only travels with compute commands.
    assign opcode_w = mode_i + 2'd1;
    assign func_w   = (mode_i == 2'b10) ? func_i : '0;
    assign hs       = pending_q & cmd_ready_i;

    generate
        for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_slice
            localparam logic [ADDR_W-1:0] OFFSET = ADDR_W'(gi);
            assign slice_w[gi*CW +: CW] = {opcode_w, func_w, base_addr_i + OFFSET};
        end
    endgenerate

`ifdef UNIT_SCHEDULER_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q [NUM_UNITS];
    logic [WD_W-1:0] wd_d [NUM_UNITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_UNITS; i++) wd_q[i] <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            active_q  <= '0;
            data_q    <= '0;
            error_q   <= 1'b0;
            tmask_q   <= '0;
            cnt_q     <= '0;
            perf_q    <= '0;
            batch_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            data_q    <= data_d;
            error_q   <= error_d;
            tmask_q   <= tmask_d;
            cnt_q     <= cnt_d;
            perf_q    <= perf_d;
            batch_q   <= batch_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        active_d  = active_q;
        data_d    = data_q;
        error_d   = error_q;
        tmask_d   = tmask_q;
        cnt_d     = cnt_q;
        perf_d    = perf_q;
        batch_d   = batch_q;
`ifdef UNIT_SCHEDULER_WATCHDOG_EN
        wd_d      = wd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (mode_i == 2'b11) begin
                        error_d = 1'b1;
                    end else begin
                        error_d = 1'b0;
                        tmask_d = '0;
                        state_d = S_INIT;
                    end
                end
            end
            S_INIT: begin
                pending_d = unit_enable_i;
                active_d  = '0;
                cnt_d     = '0;
                data_d    = slice_w;
                state_d   = (unit_enable_i == '0) ? S_SYNC : S_DISPATCH;
            end
            S_DISPATCH, S_EXECUTE: begin
                cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                pending_d = pending_q & ~hs;
                // A done pulse in the handshake cycle is dropped: the unit is not active yet.
                active_d  = (active_q & ~unit_done_i) | hs;
`ifdef UNIT_SCHEDULER_WATCHDOG_EN
                for (int i = 0; i < NUM_UNITS; i++) begin
                    if (hs[i]) begin
                        wd_d[i] = '0;
                    end else if (active_q[i] && !unit_done_i[i]) begin
                        if (wd_q[i] == WD_W'(TIMEOUT - 1)) begin
                            tmask_d[i]  = 1'b1;
                            error_d     = 1'b1;
                            active_d[i] = 1'b0;
                        end
                        wd_d[i] = wd_q[i] + 1'b1;
                    end
                end
`endif
                if (state_q == S_DISPATCH) begin
                    if (pending_d == '0) state_d = S_EXECUTE;
                end else if (active_d == '0) begin
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                perf_d  = cnt_q;
                batch_d = (batch_q == 16'hFFFF) ? batch_q : batch_q + 16'd1;
                state_d = continue_en_i ? S_INIT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything decided above, including SYNC bookkeeping.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            pending_d = '0;
            active_d  = '0;
            error_d   = error_q;
            tmask_d   = tmask_q;
            perf_d    = perf_q;
            batch_d   = batch_q;
        end
    end

    assign busy_o         = (state_q != S_IDLE);
    assign sync_o         = (state_q == S_SYNC);
    assign cmd_valid_o    = pending_q;
    assign cmd_data_o     = data_q;
    assign error_o        = error_q;
    assign active_mask_o  = active_q;
    assign timeout_mask_o = tmask_q;
    assign perf_cycles_o  = perf_q;
    assign batch_count_o  = batch_q;

endmodule

// File: doc/unit_scheduler.md
Name: unit_scheduler

Overview:
- Parametrised successor to the fixed 4-unit system controller.
- Sequences batches of load/store/compute commands to NUM_UNITS processing units over per-unit valid/ready command handshakes.
- Tracks per-unit completion, reports batch latency and batch count, and supports abort and continuous batching.
- Sits between the host control registers and the processing-unit array.

Parameters:
- NUM_UNITS, 4, number of processing units (1..16).
- ADDR_W, 4, data address width per command.
- FUNC_W, 2, compute-type field width.
- PERF_W, 16, width of the batch cycle counter.
- TIMEOUT, 255, watchdog limit in cycles (used only with UNIT_SCHEDULER_WATCHDOG_EN).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin batch (sampled in IDLE).
- abort  in  1  synchronous abort, any state.
- continue_en  in  1  at SYNC: 1 = start next batch, 0 = return to IDLE.
- mode  in  2  00 load, 01 store, 10 compute, 11 illegal.
- func  in  FUNC_W  compute type, passed in compute commands.
- base_addr  in  ADDR_W  address of unit 0; unit i gets base_addr+i mod 2^ADDR_W.
- unit_enable  in  NUM_UNITS  units participating in the batch, latched at INIT.
- cmd_valid  out  NUM_UNITS  per-unit command valid.
- cmd_ready  in  NUM_UNITS  per-unit command ready.
- cmd_data  out  NUM_UNITS*(2+FUNC_W+ADDR_W)  per-unit {opcode[1:0], func, addr}; unit i at slice i. Opcodes: 01 load, 10 store, 11 compute.
- unit_done  in  NUM_UNITS  per-unit single-cycle completion pulse.
- busy  out  1  state != IDLE.
- sync  out  1  state == SYNC.
- error  out  1  sticky error flag.
- active_mask  out  NUM_UNITS  units holding an accepted, uncompleted command.
- timeout_mask  out  NUM_UNITS  units that hit the watchdog (sticky).
- perf_cycles  out  PERF_W  cycle count of the last completed batch.
- batch_count  out  16  completed batches, saturating.

Behaviour:
- Reset: every output and register is 0; state IDLE.
- Status outputs (busy, sync) decode from the state register; all other outputs are registered.
- Command slice encoding:
  - func field is 0 unless mode = 10.
  - addr is base_addr+i, truncated to ADDR_W (wraps).
- IDLE:
  - start with mode != 11: clear error and timeout_mask, go to INIT.
  - start with mode == 11: set error, stay in IDLE.
- INIT (1 cycle):
  - pending <= unit_enable; active_mask <= 0; cycle counter <= 0.
  - Latch mode, func and base_addr for the whole batch.
  - If unit_enable == 0, go to SYNC; else go to DISPATCH.
- DISPATCH:
  - cmd_valid[i] = pending[i].
  - cmd_data is stable while valid is held; valid never drops before acceptance unless abort.
  - On cmd_valid[i] & cmd_ready[i]: clear pending[i], set active_mask[i] on the next edge.
  - Go to EXECUTE when pending becomes 0.
- EXECUTE:
  - unit_done[i] & active_mask[i] clears active_mask[i].
  - Go to SYNC when active_mask == 0 and pending == 0.
- Done handling in DISPATCH: done processing is identical there.
- Ignored done pulses: unit_done for a unit not active, or arriving in the same cycle as that unit's handshake, is ignored.
- Cycle counter: increments every cycle in DISPATCH and EXECUTE; saturates at all-ones.
- SYNC (1 cycle):
  - perf_cycles <= cycle counter; batch_count += 1, saturating at 16'hFFFF.
  - continue_en = 1: go to INIT (re-latches unit_enable and the other inputs).
  - continue_en = 0: go to IDLE.
- Abort (any non-IDLE state): next edge cmd_valid = 0, pending = 0, active_mask = 0, state IDLE. perf_cycles and batch_count are unchanged; error is not set. Abort has priority over every transition.
- Reset mid-batch: immediate return to reset values; no command stays valid.

Optional Feature:
- Macro: UNIT_SCHEDULER_WATCHDOG_EN.
- Defined:
  - Each active unit has a counter, cleared on handshake, incremented each active cycle.
  - When a counter reaches TIMEOUT without done: set timeout_mask[i], set error, clear active_mask[i]. The batch then completes normally via SYNC.
- Undefined: no counters; timeout_mask is tied to 0; error is set only by the illegal-mode start.

Test Plan:
- NUM_UNITS=4, unit_enable=4'b1111, mode=10, func=2'b01, base_addr=4'hE, all ready, start pulse → one cycle later cmd_valid=4'b1111 with addrs E,F,0,1 and opcode 11. Drive done after 3 cycles → SYNC, perf_cycles=4, batch_count=1, IDLE.
- Unit 2 cmd_ready held low 5 cycles → cmd_valid[2] stays high with stable data; state stays DISPATCH until accepted; others go active.
- unit_done[1] pulse while active_mask[1]=0 → no change; done in the same cycle as unit 3 handshake → active_mask[3]=1 afterwards.
- continue_en=1 for 3 batches with unit_enable=4'b0101 → only units 0 and 2 receive commands; batch_count=3 at the end.
- start with mode=11 → error=1, busy=0. Then valid start → error=0. Abort during EXECUTE → next cycle busy=0, active_mask=0.
- Watchdog on, TIMEOUT=8, unit 1 never done → timeout_mask=4'b0010, error=1, batch reaches SYNC.
